// File: rtl/ram_io_pkg.sv
// Shared encodings, FSM states and access-size lookup for ram_io.
package ram_io_pkg;

   typedef enum logic [1:0] {
      WT_NONE = 2'b00,
      WT_BYTE = 2'b01,
      WT_HALF = 2'b10,
      WT_WORD = 2'b11
   } write_type_e;

   typedef enum logic [2:0] {
      RT_NONE   = 3'b000,
      RT_BYTE_S = 3'b001,
      RT_HALF_S = 3'b010,
      RT_WORD   = 3'b011,
      RT_BYTE_U = 3'b101,
      RT_HALF_U = 3'b110
   } read_type_e;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ACCESS_LO = 2'd1,
`ifdef RAM_IO_MISALIGNED_EN
      ST_ACCESS_HI = 2'd2,
`endif
      ST_DONE      = 2'd3
   } state_e;

   // Byte count for a size code; the low two bits of both type encodings share it.
   function automatic logic [2:0] access_size(input logic [1:0] code);
      case (code)
         WT_BYTE: return 3'd1;
         WT_HALF: return 3'd2;
         WT_WORD: return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

endpackage

// File: rtl/ram_io_extend.sv
// Sign/zero extension of an assembled read value according to read_type.
module ram_io_extend
   import ram_io_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [2:0]  read_type,
   output logic [31:0] ext
);

   always_comb begin
      ext = '0;
      case (read_type)
         RT_BYTE_S: ext = {{24{raw[7]}}, raw[7:0]};
         RT_HALF_S: ext = {{16{raw[15]}}, raw[15:0]};
         RT_BYTE_U: ext = {24'h0, raw[7:0]};
         RT_HALF_U: ext = {16'h0, raw[15:0]};
         RT_WORD, 3'b111: ext = raw;
         default:   ext = '0;
      endcase
   end

endmodule

// File: rtl/ram_io.sv
// Byte/half/word load-store adapter onto a word-wide RAM.
// Define RAM_IO_MISALIGNED_EN to split word-spanning accesses; otherwise they are rejected with error.
module ram_io
   import ram_io_pkg::*;
#(
   parameter int unsigned ADDRESS_BITWIDTH = 16,
   parameter int unsigned DATA_BITWIDTH    = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [ADDRESS_BITWIDTH+1:0]   addr,
   input  logic [1:0]                    write_type,
   input  logic [2:0]                    read_type,
   input  logic [DATA_BITWIDTH-1:0]      data_in,
   output logic [DATA_BITWIDTH-1:0]      data_out,
   output logic                          done,
   output logic                          error,
   output logic                          ram_write_enable,
   output logic [ADDRESS_BITWIDTH-1:0]   ram_address,
   output logic [DATA_BITWIDTH-1:0]      ram_data_in,
   input  logic [DATA_BITWIDTH-1:0]      ram_data_out
);

`ifdef RAM_IO_MISALIGNED_EN
   localparam int unsigned LANES = 8;
`else
   localparam int unsigned LANES = 4;
`endif
   localparam int unsigned SH_W = 8 * LANES;

   state_e                      state_q, state_d;
   logic [ADDRESS_BITWIDTH+1:0] addr_q, addr_d;
   logic [1:0]                  wtype_q, wtype_d;
   logic [2:0]                  rtype_q, rtype_d;
   logic [31:0]                 wdata_q, wdata_d;
   logic [31:0]                 data_out_q, data_out_d;
   logic                        error_q, error_d;
`ifdef RAM_IO_MISALIGNED_EN
   logic [31:0]                 rd_lo_q, rd_lo_d;
`endif

   logic [1:0]                  off;
   logic [1:0]                  access_code;
   logic [2:0]                  size;
   logic                        spanning;
   logic                        is_write;
   logic                        is_read;
   logic                        reject;
   logic                        in_access;
   logic                        in_hi;
   logic [3:0]                  size_mask;
   logic [LANES-1:0]            lane_mask;
   logic [SH_W-1:0]             wdata_sh;
   logic [SH_W-1:0]             rd_window;
   logic [3:0]                  cur_mask;
   logic [31:0]                 cur_wdata;
   logic [ADDRESS_BITWIDTH-1:0] word_lo;
   logic [31:0]                 rd_raw;
   logic [31:0]                 rd_ext;

   assign off         = addr_q[1:0];
   assign word_lo     = addr_q[ADDRESS_BITWIDTH+1:2];
   assign access_code = (wtype_q != WT_NONE) ? wtype_q : rtype_q[1:0];
   assign size        = access_size(access_code);
   assign spanning    = ({1'b0, off} + size) > 3'd4;
   assign is_write    = wtype_q != WT_NONE;
   assign is_read     = rtype_q != RT_NONE;

   always_comb begin
      size_mask = 4'b0000;
      case (size)
         3'd1:    size_mask = 4'b0001;
         3'd2:    size_mask = 4'b0011;
         3'd4:    size_mask = 4'b1111;
         default: size_mask = 4'b0000;
      endcase
   end

   // Byte lanes and data are laid out across a two-word window starting at word_lo.
   assign lane_mask = LANES'(8'(size_mask) << off);
   assign wdata_sh  = SH_W'(64'(wdata_q) << {off, 3'b000});

`ifdef RAM_IO_MISALIGNED_EN
   assign reject    = 1'b0;
   assign in_hi     = state_q == ST_ACCESS_HI;
   assign in_access = (state_q == ST_ACCESS_LO) || in_hi;
   assign cur_mask  = in_hi ? lane_mask[7:4] : lane_mask[3:0];
   assign cur_wdata = in_hi ? wdata_sh[63:32] : wdata_sh[31:0];
   assign rd_window = in_hi ? {ram_data_out, rd_lo_q} : {32'h0, ram_data_out};
`else
   assign reject    = spanning;
   assign in_hi     = 1'b0;
   assign in_access = state_q == ST_ACCESS_LO;
   assign cur_mask  = lane_mask;
   assign cur_wdata = wdata_sh;
   assign rd_window = ram_data_out;
`endif

   assign rd_raw = 32'(rd_window >> {off, 3'b000});

   ram_io_extend u_extend (
      .raw       (rd_raw),
      .read_type (rtype_q),
      .ext       (rd_ext)
   );

   always_comb begin
      ram_address      = in_hi ? word_lo + ADDRESS_BITWIDTH'(1) : word_lo;
      ram_write_enable = in_access && is_write && !reject && (cur_mask != 4'b0000);
      ram_data_in      = ram_data_out;
      for (int unsigned i = 0; i < 4; i++) begin
         if (cur_mask[i]) ram_data_in[8*i +: 8] = cur_wdata[8*i +: 8];
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wtype_d    = wtype_q;
      rtype_d    = rtype_q;
      wdata_d    = wdata_q;
      data_out_d = data_out_q;
      error_d    = 1'b0;
`ifdef RAM_IO_MISALIGNED_EN
      rd_lo_d    = rd_lo_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d  = addr;
               wtype_d = write_type;
               rtype_d = (write_type != WT_NONE) ? RT_NONE : read_type;
               wdata_d = data_in;
               state_d = ST_ACCESS_LO;
            end
         end
         ST_ACCESS_LO: begin
`ifdef RAM_IO_MISALIGNED_EN
            if (spanning) begin
               rd_lo_d = ram_data_out;
               state_d = ST_ACCESS_HI;
            end else begin
               if (is_read) data_out_d = rd_ext;
               state_d = ST_DONE;
            end
`else
            if (spanning) begin
               error_d    = 1'b1;
               data_out_d = '0;
            end else if (is_read) begin
               data_out_d = rd_ext;
            end
            state_d = ST_DONE;
`endif
         end
`ifdef RAM_IO_MISALIGNED_EN
         ST_ACCESS_HI: begin
            if (is_read) data_out_d = rd_ext;
            state_d = ST_DONE;
         end
`endif
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         wtype_q    <= '0;
         rtype_q    <= '0;
         wdata_q    <= '0;
         data_out_q <= '0;
         error_q    <= 1'b0;
`ifdef RAM_IO_MISALIGNED_EN
         rd_lo_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wtype_q    <= wtype_d;
         rtype_q    <= rtype_d;
         wdata_q    <= wdata_d;
         data_out_q <= data_out_d;
         error_q    <= error_d;
`ifdef RAM_IO_MISALIGNED_EN
         rd_lo_q    <= rd_lo_d;
`endif
      end
   end

   assign req_ready = state_q == ST_IDLE;
   assign done      = state_q == ST_DONE;
   assign error     = error_q;
   assign data_out  = data_out_q;

endmodule

// File: tb/tb_ram_io.sv
// Self-checking bench for ram_io against a byte-array reference model.
module tb_ram_io;

   localparam int AW     = 4;
   localparam int NWORDS = 1 << AW;
   localparam int NBYTES = 4 * NWORDS;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [AW+1:0] addr;
   logic [1:0]    write_type;
   logic [2:0]    read_type;
   logic [31:0]   data_in;
   logic [31:0]   data_out;
   logic          done;
   logic          error;
   logic          ram_write_enable;
   logic [AW-1:0] ram_address;
   logic [31:0]   ram_data_in;
   logic [31:0]   ram_data_out;

   always #5 clk = ~clk;

   ram_io #(.ADDRESS_BITWIDTH(AW), .DATA_BITWIDTH(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .addr             (addr),
      .write_type       (write_type),
      .read_type        (read_type),
      .data_in          (data_in),
      .data_out         (data_out),
      .done             (done),
      .error            (error),
      .ram_write_enable (ram_write_enable),
      .ram_address      (ram_address),
      .ram_data_in      (ram_data_in),
      .ram_data_out     (ram_data_out)
   );

   // RAM with combinational read and synchronous write
   logic [31:0] ram [NWORDS] = '{default: '0};
   int          wr_cnt = 0;
   assign ram_data_out = ram[ram_address];
   always @(posedge clk) begin
      if (ram_write_enable) begin
         ram[ram_address] <= ram_data_in;
         wr_cnt <= wr_cnt + 1;
      end
   end

   int          errors = 0;
   int          checks = 0;
   logic [7:0]  mb [NBYTES];
   logic [31:0] exp_dout;

   int          t_lat;
   int          t_writes;
   logic        t_err;
   logic [31:0] t_dout;
   bit          t_ready_low;
   bit          t_accept_ok;
   bit          t_timeout;

   int          m_lat;
   int          m_writes;
   logic        m_err;

   function automatic int size_of(input logic [1:0] code);
      return (code == 2'd1) ? 1 : (code == 2'd2) ? 2 : (code == 2'd3) ? 4 : 0;
   endfunction

   function automatic logic [31:0] mword(input int w);
      return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
   endfunction

   // Reference: byte-addressed memory with modulo wrap, little-endian byte order.
   task automatic model_req(input logic [AW+1:0] a, input logic [1:0] wt,
                            input logic [2:0] rt, input logic [31:0] din);
      logic [2:0]  rte;
      int          sz;
      bit          span;
      logic [31:0] v;
      rte = (wt != 2'd0) ? 3'd0 : rt;
      sz = (wt != 2'd0) ? size_of(wt) : size_of(rte[1:0]);
      span = (int'(a[1:0]) + sz) > 4;
      m_lat = span ? 3 : 2;
      m_err = 1'b0;
      m_writes = 0;
`ifndef RAM_IO_MISALIGNED_EN
      if (span) begin
         m_lat = 2;
         m_err = 1'b1;
         exp_dout = '0;
         return;
      end
`endif
      if (wt != 2'd0) begin
         for (int i = 0; i < sz; i++) mb[(int'(a) + i) % NBYTES] = din[8*i +: 8];
         m_writes = span ? 2 : 1;
      end else if (sz != 0) begin
         v = '0;
         for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[(int'(a) + i) % NBYTES];
         if (rte == 3'd1 && v[7])  v = v | 32'hFFFF_FF00;
         if (rte == 3'd2 && v[15]) v = v | 32'hFFFF_0000;
         exp_dout = v;
      end
   endtask

   // Issue one request from IDLE and observe it through its done pulse.
   task automatic run_req(input logic [AW+1:0] a, input logic [1:0] wt,
                          input logic [2:0] rt, input logic [31:0] din);
      int wr0;
      addr = a; write_type = wt; read_type = rt; data_in = din; req_valid = 1'b1;
      #1;
      t_accept_ok = req_ready;
      wr0 = wr_cnt;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      addr = AW'($urandom); write_type = 2'($urandom); read_type = 3'($urandom); data_in = $urandom;
      t_lat = 1; t_ready_low = 1; t_timeout = 1; t_err = 1'b0; t_dout = '0;
      for (int k = 0; k < 8; k++) begin
         if (done) begin
            t_timeout = 0; t_err = error; t_dout = data_out;
            break;
         end
         if (req_ready) t_ready_low = 0;
         @(negedge clk);
         t_lat++;
      end
      @(negedge clk);
      t_writes = wr_cnt - wr0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; addr = '0; write_type = '0; read_type = '0; data_in = '0;
      for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
      exp_dout = '0;
      repeat (3) @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b want=0", error); end
      checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_dout got=%h want=0", data_out); end
      checks++; if (ram_write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got=%b want=0", ram_write_enable); end
      rst = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", req_ready); end
      @(negedge clk);
   endtask

   task automatic test_word_write();
      model_req(6'h08, 2'd3, 3'd0, 32'hDEAD_BEEF);
      run_req(6'h08, 2'd3, 3'd0, 32'hDEAD_BEEF);
      checks++; if (t_timeout || !t_accept_ok) begin errors++; $display("FAIL ww_handshake timeout=%0d accept=%0d want 0/1", t_timeout, t_accept_ok); end
      checks++; if (t_lat !== 2) begin errors++; $display("FAIL ww_latency got=%0d want=2", t_lat); end
      checks++; if (t_ready_low !== 1'b1) begin errors++; $display("FAIL ww_ready_busy got=ready_high want=ready_low"); end
      checks++; if (ram[2] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ww_word2 got=%h want=deadbeef", ram[2]); end
      checks++; if (t_writes !== 1) begin errors++; $display("FAIL ww_writes got=%0d want=1", t_writes); end
   endtask

   task automatic test_byte_rw();
      model_req(6'h04, 2'd3, 3'd0, 32'h1122_3344); run_req(6'h04, 2'd3, 3'd0, 32'h1122_3344);
      model_req(6'h05, 2'd1, 3'd0, 32'h5A5A_5A80); run_req(6'h05, 2'd1, 3'd0, 32'h5A5A_5A80);
      checks++; if (t_dout !== exp_dout) begin errors++; $display("FAIL byte_write_dout got=%h want=%h", t_dout, exp_dout); end
      checks++; if (ram[1] !== 32'h1122_8044) begin errors++; $display("FAIL byte_word1 got=%h want=11228044", ram[1]); end
      model_req(6'h05, 2'd0, 3'd1, 32'h0); run_req(6'h05, 2'd0, 3'd1, 32'h0);
      checks++; if (t_dout !== 32'hFFFF_FF80) begin errors++; $display("FAIL byte_read_s got=%h want=ffffff80", t_dout); end
      checks++; if (t_writes !== 0) begin errors++; $display("FAIL byte_read_writes got=%0d want=0", t_writes); end
      model_req(6'h05, 2'd0, 3'd5, 32'h0); run_req(6'h05, 2'd0, 3'd5, 32'h0);
      checks++; if (t_dout !== 32'h0000_0080) begin errors++; $display("FAIL byte_read_u got=%h want=00000080", t_dout); end
   endtask

   task automatic test_spanning();
`ifdef RAM_IO_MISALIGNED_EN
      model_req(6'h03, 2'd2, 3'd0, 32'h0000_ABCD); run_req(6'h03, 2'd2, 3'd0, 32'h0000_ABCD);
      checks++; if (ram[0][31:24] !== 8'hCD) begin errors++; $display("FAIL span_w0 got=%h want=cd", ram[0][31:24]); end
      checks++; if (ram[1][7:0] !== 8'hAB) begin errors++; $display("FAIL span_w1 got=%h want=ab", ram[1][7:0]); end
      checks++; if (t_lat !== 3) begin errors++; $display("FAIL span_latency got=%0d want=3", t_lat); end
      checks++; if (t_writes !== 2) begin errors++; $display("FAIL span_writes got=%0d want=2", t_writes); end
      model_req(6'h03, 2'd0, 3'd2, 32'h0); run_req(6'h03, 2'd0, 3'd2, 32'h0);
      checks++; if (t_dout !== 32'hFFFF_ABCD) begin errors++; $display("FAIL span_read got=%h want=ffffabcd", t_dout); end
`else
      model_req(6'h04, 2'd0, 3'd3, 32'h0); run_req(6'h04, 2'd0, 3'd3, 32'h0);
      checks++; if (t_dout !== 32'h1122_8044) begin errors++; $display("FAIL rej_pre_read got=%h want=11228044", t_dout); end
      model_req(6'h01, 2'd3, 3'd0, 32'h0102_0304); run_req(6'h01, 2'd3, 3'd0, 32'h0102_0304);
      checks++; if (t_err !== 1'b1) begin errors++; $display("FAIL rej_error got=%b want=1", t_err); end
      checks++; if (t_dout !== 32'h0) begin errors++; $display("FAIL rej_dout got=%h want=0", t_dout); end
      checks++; if (t_writes !== 0) begin errors++; $display("FAIL rej_writes got=%0d want=0", t_writes); end
      checks++; if (t_lat !== 2) begin errors++; $display("FAIL rej_latency got=%0d want=2", t_lat); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL rej_error_clear got=%b want=0", error); end
`endif
   endtask

   task automatic test_wrap();
      model_req(6'h3E, 2'd3, 3'd0, 32'h1234_5678); run_req(6'h3E, 2'd3, 3'd0, 32'h1234_5678);
`ifdef RAM_IO_MISALIGNED_EN
      checks++; if (ram[15][31:16] !== 16'h5678) begin errors++; $display("FAIL wrap_w15 got=%h want=5678", ram[15][31:16]); end
      checks++; if (ram[0][15:0] !== 16'h1234) begin errors++; $display("FAIL wrap_w0 got=%h want=1234", ram[0][15:0]); end
      checks++; if (t_lat !== 3) begin errors++; $display("FAIL wrap_latency got=%0d want=3", t_lat); end
`else
      checks++; if (t_err !== 1'b1 || t_writes !== 0) begin errors++; $display("FAIL wrap_reject err=%b writes=%0d want 1/0", t_err, t_writes); end
`endif
   endtask

   task automatic test_random();
      logic [2:0]    rts [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
      logic [AW+1:0] a;
      logic [1:0]    wt;
      logic [2:0]    rt;
      logic [31:0]   din;
      for (int n = 0; n < 150; n++) begin
         a = (AW+2)'($urandom);
         wt = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
         rt = rts[$urandom_range(0, 5)];
         din = $urandom;
         model_req(a, wt, rt, din);
         run_req(a, wt, rt, din);
         checks++; if (t_timeout || !t_accept_ok) begin errors++; $display("FAIL rnd_handshake n=%0d timeout=%0d accept=%0d", n, t_timeout, t_accept_ok); end
         checks++; if (t_lat !== m_lat) begin errors++; $display("FAIL rnd_latency n=%0d got=%0d want=%0d", n, t_lat, m_lat); end
         checks++; if (t_err !== m_err) begin errors++; $display("FAIL rnd_error n=%0d got=%b want=%b", n, t_err, m_err); end
         checks++; if (t_dout !== exp_dout) begin errors++; $display("FAIL rnd_dout n=%0d a=%h wt=%0d rt=%0d got=%h want=%h", n, a, wt, rt, t_dout, exp_dout); end
         checks++; if (data_out !== exp_dout) begin errors++; $display("FAIL rnd_dout_hold n=%0d got=%h want=%h", n, data_out, exp_dout); end
         checks++; if (t_writes !== m_writes) begin errors++; $display("FAIL rnd_writes n=%0d got=%0d want=%0d", n, t_writes, m_writes); end
         for (int w = 0; w < NWORDS; w++) begin
            checks++; if (ram[w] !== mword(w)) begin errors++; $display("FAIL rnd_ram n=%0d word=%0d got=%h want=%h", n, w, ram[w], mword(w)); end
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] w4;
      bit          saw_done;
      w4 = mword(4);
      addr = 6'h0E; write_type = 2'd3; read_type = 3'd0; data_in = 32'hCAFE_F00D; req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b want=0", req_ready); end
      rst = 1'b1;
      #1;
      checks++; if (ram_write_enable !== 1'b0) begin errors++; $display("FAIL mid_we got=%b want=0", ram_write_enable); end
      saw_done = done;
      repeat (2) begin @(negedge clk); saw_done |= done; end
      rst = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got=%b want=1", req_ready); end
      checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL mid_dout got=%h want=0", data_out); end
      repeat (4) begin @(negedge clk); saw_done |= done; end
      checks++; if (saw_done) begin errors++; $display("FAIL mid_done got=pulsed want=none"); end
      checks++; if (ram[4] !== w4) begin errors++; $display("FAIL mid_word4 got=%h want=%h", ram[4], w4); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_word_write();
      test_byte_rw();
      test_spanning();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
